// File: rtl/register_file_if.sv
// Decode / commit / operand bus between the decoder, the ROB commit port and the
// architectural register file. The register file connects through the slave modport.
interface register_file_if #(
  parameter int XLEN             = 32,
  parameter int REG_CNT_WIDTH    = 5,
  parameter int ROB_SIZE_WIDTH   = 3,
  parameter int DEPENDENCY_WIDTH = ROB_SIZE_WIDTH + 1
);
  logic                        rdy;
  logic                        flush;
  logic                        stall;

  logic                        dec_ready;
  logic [REG_CNT_WIDTH-1:0]    dec_rs1;
  logic [REG_CNT_WIDTH-1:0]    dec_rs2;
  logic [REG_CNT_WIDTH-1:0]    dec_rd;
  logic                        dec_writes_rd;
  logic [ROB_SIZE_WIDTH-1:0]   dec_rob_id;

  logic                        rob_rf_enable;
  logic [REG_CNT_WIDTH-1:0]    rob_rf_rd;
  logic [XLEN-1:0]             rob_rf_val;
  logic [ROB_SIZE_WIDTH-1:0]   rob_rf_id;

  logic [XLEN-1:0]             rf_val1;
  logic [XLEN-1:0]             rf_val2;
  logic [DEPENDENCY_WIDTH-1:0] rf_dep1;
  logic [DEPENDENCY_WIDTH-1:0] rf_dep2;
  logic                        rf_stall;

  modport master (
    output rdy, flush, stall,
    output dec_ready, dec_rs1, dec_rs2, dec_rd, dec_writes_rd, dec_rob_id,
    output rob_rf_enable, rob_rf_rd, rob_rf_val, rob_rf_id,
    input  rf_val1, rf_val2, rf_dep1, rf_dep2, rf_stall
  );

  modport slave (
    input  rdy, flush, stall,
    input  dec_ready, dec_rs1, dec_rs2, dec_rd, dec_writes_rd, dec_rob_id,
    input  rob_rf_enable, rob_rf_rd, rob_rf_val, rob_rf_id,
    output rf_val1, rf_val2, rf_dep1, rf_dep2, rf_stall
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file with ROB rename tags: supplies operands as value or tag,
// renames rd at decode, retires commits. Define RF_COMMIT_BYPASS_EN to forward commits.
module register_file #(
  parameter int XLEN             = 32,
  parameter int REG_CNT_WIDTH    = 5,
  parameter int ROB_SIZE_WIDTH   = 3,
  parameter int DEPENDENCY_WIDTH = ROB_SIZE_WIDTH + 1
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);

  localparam int REG_CNT = 1 << REG_CNT_WIDTH;

  typedef logic [REG_CNT_WIDTH-1:0]    reg_idx_t;
  typedef logic [ROB_SIZE_WIDTH-1:0]   rob_id_t;
  typedef logic [DEPENDENCY_WIDTH-1:0] dep_t;

  localparam dep_t DEP_READY = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

  logic [XLEN-1:0]    regs_q [REG_CNT];
  logic [XLEN-1:0]    regs_d [REG_CNT];
  logic [REG_CNT-1:0] busy_q, busy_d;
  rob_id_t            tag_q  [REG_CNT];
  rob_id_t            tag_d  [REG_CNT];

  logic     commit_wr;
  logic     commit_release;
  logic     rename_en;
  reg_idx_t rs      [2];
  logic     fwd_hit [2];
  logic [XLEN-1:0] rd_val [2];
  dep_t            rd_dep [2];

  // A commit only frees the register when it is the youngest rename of that rd.
  assign commit_wr      = bus.rob_rf_enable && (bus.rob_rf_rd != '0);
  assign commit_release = commit_wr && busy_q[bus.rob_rf_rd]
                          && (tag_q[bus.rob_rf_rd] == bus.rob_rf_id);

  assign rename_en = bus.dec_ready && !bus.stall && !bus.rf_stall
                     && bus.dec_writes_rd && (bus.dec_rd != '0);

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    rs[0] = bus.dec_rs1;
    rs[1] = bus.dec_rs2;
    for (int p = 0; p < 2; p++) begin
      fwd_hit[p] = commit_release && (rs[p] == bus.rob_rf_rd);
      rd_val[p]  = '0;
      rd_dep[p]  = DEP_READY;
      if (rs[p] != '0) begin
        if (!busy_q[rs[p]]) begin
          rd_val[p] = regs_q[rs[p]];
`ifdef RF_COMMIT_BYPASS_EN
        end else if (fwd_hit[p]) begin
          rd_val[p] = bus.rob_rf_val;
`endif
        end else begin
          rd_dep[p] = {1'b0, tag_q[rs[p]]};
        end
      end
    end
  end

  assign bus.rf_val1 = rd_val[0];
  assign bus.rf_val2 = rd_val[1];
  assign bus.rf_dep1 = rd_dep[0];
  assign bus.rf_dep2 = rd_dep[1];

`ifdef RF_COMMIT_BYPASS_EN
  assign bus.rf_stall = 1'b0;
`else
  // Without forwarding, hold decode one cycle so the operand comes from regs.
  assign bus.rf_stall = bus.dec_ready && (fwd_hit[0] || fwd_hit[1]);
`endif

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (bus.rdy) begin
      if (rst) begin
        // NOTE: the register array is deliberately cleared on reset because
        // reads after reset must return 0; most RAM-like arrays are not reset.
        for (int i = 0; i < REG_CNT; i++) begin
          regs_d[i] = '0;
          tag_d[i]  = '0;
        end
        busy_d = '0;
      end else begin
        if (commit_wr) begin
          regs_d[bus.rob_rf_rd] = bus.rob_rf_val;
          if (commit_release) busy_d[bus.rob_rf_rd] = 1'b0;
        end
        // Flush still keeps the commit above: the redirecting branch/JALR retires now.
        if (bus.flush) begin
          busy_d = '0;
        end else if (rename_en) begin
          busy_d[bus.dec_rd] = 1'b1;
          tag_d[bus.dec_rd]  = bus.dec_rob_id;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
    tag_q  <= tag_d;
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed test-plan scenarios plus random traffic,
// checked against an array-based behavioural model of the rename/commit rules.
module tb_register_file;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int IW   = 3;
  localparam int DW   = IW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_if #(.XLEN(XLEN), .REG_CNT_WIDTH(RW), .ROB_SIZE_WIDTH(IW)) bus ();

  register_file #(.XLEN(XLEN), .REG_CNT_WIDTH(RW), .ROB_SIZE_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [XLEN-1:0] val1;
    logic [DW-1:0]   dep1;
    logic [XLEN-1:0] val2;
    logic [DW-1:0]   dep2;
    logic            stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   model_valid = 0;

  logic [XLEN-1:0] m_regs [32];
  bit              m_busy [32];
  logic [IW-1:0]   m_tag  [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operand rules: x0 and idle registers are ready; a busy register is ready only
  // when forwarded from a releasing commit, otherwise it reports its tag.
  function automatic exp_t predict();
    exp_t e;
    int   src [2];
    bit   rel [2];
    logic [XLEN-1:0] v [2];
    logic [DW-1:0]   d [2];
    src[0] = int'(bus.dec_rs1);
    src[1] = int'(bus.dec_rs2);
    for (int p = 0; p < 2; p++) begin
      rel[p] = bus.rob_rf_enable && src[p] != 0 && src[p] == int'(bus.rob_rf_rd)
               && m_busy[src[p]] && m_tag[src[p]] == bus.rob_rf_id;
      v[p] = '0;
      d[p] = 4'b1000;
      if (src[p] != 0 && !m_busy[src[p]]) v[p] = m_regs[src[p]];
`ifdef RF_COMMIT_BYPASS_EN
      else if (src[p] != 0 && rel[p]) v[p] = bus.rob_rf_val;
`endif
      else if (src[p] != 0) d[p] = {1'b0, m_tag[src[p]]};
    end
    e.val1 = v[0]; e.dep1 = d[0];
    e.val2 = v[1]; e.dep2 = d[1];
`ifdef RF_COMMIT_BYPASS_EN
    e.stall = 1'b0;
`else
    e.stall = bus.dec_ready && (rel[0] || rel[1]);
`endif
    return e;
  endfunction

  task automatic model_step(input bit stall_now);
    int crd, drd;
    if (!bus.rdy) return;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
      end
      model_valid = 1;
      return;
    end
    crd = int'(bus.rob_rf_rd);
    drd = int'(bus.dec_rd);
    if (bus.rob_rf_enable && crd != 0) begin
      m_regs[crd] = bus.rob_rf_val;
      if (m_busy[crd] && m_tag[crd] == bus.rob_rf_id) m_busy[crd] = 0;
    end
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else if (bus.dec_ready && !bus.stall && !stall_now && bus.dec_writes_rd && drd != 0) begin
      m_busy[drd] = 1;
      m_tag[drd]  = bus.dec_rob_id;
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    bus.rdy = 1'b1; bus.flush = 1'b0; bus.stall = 1'b0;
    bus.dec_ready = 1'b0; bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
    bus.dec_writes_rd = 1'b0; bus.dec_rob_id = '0;
    bus.rob_rf_enable = 1'b0; bus.rob_rf_rd = '0; bus.rob_rf_val = '0; bus.rob_rf_id = '0;
  endtask

  // Publish this cycle's expectation, advance the model, then cross the clock edge.
  task automatic step();
    exp_t e;
    e = predict();
    if (model_valid) sb_q.push_back(e);
    model_step(e.stall);
    @(posedge clk);
    #1;
  endtask

  task automatic rename(input int rd, input int id);
    idle();
    bus.dec_ready = 1'b1; bus.dec_writes_rd = 1'b1;
    bus.dec_rd = RW'(rd); bus.dec_rob_id = IW'(id);
    step();
  endtask

  task automatic commit(input int rd, input int id, input logic [XLEN-1:0] val);
    idle();
    bus.rob_rf_enable = 1'b1; bus.rob_rf_rd = RW'(rd);
    bus.rob_rf_id = IW'(id); bus.rob_rf_val = val;
    step();
  endtask

  task automatic read_chk(input string name, input int rs1, input int rs2,
                          input logic [XLEN-1:0] v1, input logic [DW-1:0] d1,
                          input logic [XLEN-1:0] v2, input logic [DW-1:0] d2);
    idle();
    bus.dec_rs1 = RW'(rs1); bus.dec_rs2 = RW'(rs2);
    #1;
    check({name, "_val1"}, 64'(bus.rf_val1), 64'(v1));
    check({name, "_dep1"}, 64'(bus.rf_dep1), 64'(d1));
    check({name, "_val2"}, 64'(bus.rf_val2), 64'(v2));
    check({name, "_dep2"}, 64'(bus.rf_dep2), 64'(d2));
    step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_val1",  64'(bus.rf_val1),  64'(e.val1));
        check("sb_dep1",  64'(bus.rf_dep1),  64'(e.dep1));
        check("sb_val2",  64'(bus.rf_val2),  64'(e.val2));
        check("sb_dep2",  64'(bus.rf_dep2),  64'(e.dep2));
        check("sb_stall", 64'(bus.rf_stall), 64'(e.stall));
      end
    end
  end

  initial begin : stimulus
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    read_chk("reset", 5, 0, 0, 4'b1000, 0, 4'b1000);
    check("reset_stall", 64'(bus.rf_stall), 64'd0);

    rename(3, 2);
    read_chk("renamed", 3, 0, 0, 4'b0010, 0, 4'b1000);
    commit(3, 2, 32'h1234);
    read_chk("committed", 3, 0, 32'h1234, 4'b1000, 0, 4'b1000);

    rename(4, 1);
    rename(4, 5);
    commit(4, 1, 32'd7);
    read_chk("stale", 4, 0, 0, 4'b0101, 0, 4'b1000);

    rename(6, 3);
    rename(7, 4);
    idle();
    bus.flush = 1'b1;
    bus.rob_rf_enable = 1'b1; bus.rob_rf_rd = 5'd1; bus.rob_rf_id = 3'd0; bus.rob_rf_val = 32'h80;
    bus.dec_ready = 1'b1; bus.dec_writes_rd = 1'b1; bus.dec_rd = 5'd9; bus.dec_rob_id = 3'd6;
    step();
    read_chk("flush_a", 6, 7, 0, 4'b1000, 0, 4'b1000);
    read_chk("flush_b", 1, 4, 32'h80, 4'b1000, 32'd7, 4'b1000);
    read_chk("flush_c", 9, 3, 0, 4'b1000, 32'h1234, 4'b1000);

    rename(3, 6);
    idle();
    bus.dec_ready = 1'b1; bus.dec_rs1 = 5'd3;
    bus.rob_rf_enable = 1'b1; bus.rob_rf_rd = 5'd3; bus.rob_rf_id = 3'd6; bus.rob_rf_val = 32'd9;
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    check("same_val1", 64'(bus.rf_val1), 64'd9);
    check("same_dep1", 64'(bus.rf_dep1), 64'b1000);
    check("same_stall", 64'(bus.rf_stall), 64'd0);
`else
    check("same_stall", 64'(bus.rf_stall), 64'd1);
    check("same_dep1", 64'(bus.rf_dep1), 64'b0110);
`endif
    step();
    read_chk("after_commit", 3, 0, 32'd9, 4'b1000, 0, 4'b1000);

    rename(0, 1);
    commit(0, 0, 32'd5);
    read_chk("x0", 0, 0, 0, 4'b1000, 0, 4'b1000);

    idle();
    bus.rdy = 1'b0;
    bus.dec_ready = 1'b1; bus.dec_writes_rd = 1'b1; bus.dec_rd = 5'd10; bus.dec_rob_id = 3'd2;
    step();
    read_chk("frozen", 10, 0, 0, 4'b1000, 0, 4'b1000);

    rename(11, 4);
    idle();
    rst = 1'b1; bus.flush = 1'b1;
    bus.rob_rf_enable = 1'b1; bus.rob_rf_rd = 5'd12; bus.rob_rf_val = 32'hdead;
    bus.dec_ready = 1'b1; bus.dec_writes_rd = 1'b1; bus.dec_rd = 5'd13; bus.dec_rob_id = 3'd1;
    step();
    read_chk("mid_reset", 11, 12, 0, 4'b1000, 0, 4'b1000);

    for (int i = 0; i < 2000; i++) begin
      int crd;
      crd = int'($urandom_range(0, 7));
      idle();
      rst               = ($urandom_range(0, 99) == 0);
      bus.rdy           = ($urandom_range(0, 9) != 0);
      bus.flush         = ($urandom_range(0, 15) == 0);
      bus.stall         = ($urandom_range(0, 7) == 0);
      bus.dec_ready     = ($urandom_range(0, 3) != 0);
      bus.dec_rs1       = ($urandom_range(0, 1) != 0) ? RW'(crd) : RW'($urandom_range(0, 7));
      bus.dec_rs2       = ($urandom_range(0, 2) != 0) ? RW'($urandom_range(0, 7)) : RW'($urandom_range(0, 31));
      bus.dec_rd        = RW'($urandom_range(0, 7));
      bus.dec_writes_rd = ($urandom_range(0, 3) != 0);
      bus.dec_rob_id    = IW'($urandom_range(0, 7));
      bus.rob_rf_enable = ($urandom_range(0, 1) != 0);
      bus.rob_rf_rd     = RW'(crd);
      bus.rob_rf_val    = $urandom;
      bus.rob_rf_id     = ($urandom_range(0, 1) != 0) ? m_tag[crd] : IW'($urandom_range(0, 7));
      step();
    end

    idle();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
